// File: rtl/id_imm_stage_pkg.sv
// CorePack: shared decode types for the front-end stages. Holds the datapath
// word type, the immediate-format selector, the RV64 opcode constants used by
// immediate decode, the skid-buffer state encoding and the buffered entry layout.
package CorePack;

    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        IMM0   = 3'd0,
        I_IMM  = 3'd1,
        S_IMM  = 3'd2,
        B_IMM  = 3'd3,
        U_IMM  = 3'd4,
        UJ_IMM = 3'd5
    } imm_op_enum;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // One buffered instruction together with its already-decoded immediate.
    typedef struct packed {
        logic [31:0] inst;
        data_t       pc;
        imm_op_enum  imm_op;
        data_t       imm;
    } entry_t;

endpackage

// File: rtl/id_imm_stage_immgen.sv
// Immgen: purely combinational RV64 immediate generator. Reassembles the
// scattered immediate bits of inst[31:7] for the selected format and
// sign-extends the result to 64 bits; IMM0 yields zero.
module Immgen
    import CorePack::*;
(
    input  logic [31:7] inst,
    input  imm_op_enum  imm_op,
    output data_t       imm
);

    // Format-specific bit reassembly with sign extension from inst[31].
    always_comb begin
        imm = '0;
        case (imm_op)
            I_IMM:   imm = {{52{inst[31]}}, inst[31:20]};
            S_IMM:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            B_IMM:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            U_IMM:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            UJ_IMM:  imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_imm_stage.sv
// id_imm_stage: decode-side immediate stage. Classifies the incoming
// instruction's immediate format, generates the sign-extended immediate on the
// input side, and buffers (inst, pc, imm_op, imm) in a two-entry skid buffer so
// that in_ready is a flop rather than a combinational function of out_ready.
module id_imm_stage
    import CorePack::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  data_t       in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output data_t       out_pc,
    output imm_op_enum  out_imm_op,
    output data_t       out_imm
);

    imm_op_enum  in_imm_op;
    data_t       in_imm;
    entry_t      in_entry;
    entry_t      main_q;
    entry_t      skid_q;
    skid_state_e state;
    logic        accept;
    logic        drain;

    // Opcode classification into the immediate format the generator should use.
    always_comb begin
        in_imm_op = IMM0;
        case (in_inst[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: in_imm_op = I_IMM;
            OPC_STORE:                                  in_imm_op = S_IMM;
            OPC_BRANCH:                                 in_imm_op = B_IMM;
            OPC_LUI, OPC_AUIPC:                         in_imm_op = U_IMM;
            OPC_JAL:                                    in_imm_op = UJ_IMM;
            default:                                    in_imm_op = IMM0;
        endcase
    end

    Immgen u_immgen (
        .inst   (in_inst[31:7]),
        .imm_op (in_imm_op),
        .imm    (in_imm)
    );

    assign in_entry = '{inst: in_inst, pc: in_pc, imm_op: in_imm_op, imm: in_imm};

    // A flushed cycle never accepts; a completed downstream handshake needs no gating.
    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready;

    // Skid-buffer FSM: state, both entry registers and the registered handshake
    // outputs all move together so in_ready/out_valid always reflect the next state.
    // NOTE: every state element here uses non-blocking assignment so all updates
    // see the pre-edge values of state, main_q and skid_q regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Entry contents are left stale; out_valid alone marks them dead.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_entry;
                        state     <= HALF;
                        out_valid <= 1'b1;
                    end
                end
                HALF: begin
                    if (accept && drain) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q   <= in_entry;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (drain) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q   <= skid_q;
                        state    <= HALF;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_inst   = main_q.inst;
    assign out_pc     = main_q.pc;
    assign out_imm_op = main_q.imm_op;
    assign out_imm    = main_q.imm;

endmodule

// File: tb/tb_id_imm_stage.sv
// tb_id_imm_stage: self-checking bench for id_imm_stage. A queue-based FIFO
// model of capacity two with arithmetic immediate reconstruction predicts the
// outputs every cycle; directed sequences pin literal expectations.
module tb_id_imm_stage;
    import CorePack::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    data_t       in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    data_t       out_pc;
    imm_op_enum  out_imm_op;
    data_t       out_imm;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        imm_op_enum  op;
        logic [63:0] imm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    id_imm_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_imm_op (out_imm_op),
        .out_imm    (out_imm)
    );

    function automatic imm_op_enum ref_op(logic [31:0] inst);
        case (inst[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: return I_IMM;
            7'h23:                      return S_IMM;
            7'h63:                      return B_IMM;
            7'h37, 7'h17:               return U_IMM;
            7'h6F:                      return UJ_IMM;
            default:                    return IMM0;
        endcase
    endfunction

    // Immediate as a signed weighted sum of its instruction fields.
    function automatic logic [63:0] ref_imm(logic [31:0] inst);
        longint s;
        longint v;
        s = longint'(inst[31]);
        case (ref_op(inst))
            I_IMM:  v = -2048 * s + longint'(inst[30:20]);
            S_IMM:  v = -2048 * s + longint'(inst[30:25]) * 32 + longint'(inst[11:7]);
            B_IMM:  v = -4096 * s + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                        + longint'(inst[11:8]) * 2;
            U_IMM:  v = -longint'(32'h8000_0000) * s + longint'(inst[30:12]) * 4096;
            UJ_IMM: v = -1048576 * s + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                        + longint'(inst[30:21]) * 2;
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            check("out_inst", 64'(out_inst), 64'(q[0].inst));
            check("out_pc", out_pc, q[0].pc);
            check("out_imm_op", 64'(out_imm_op), 64'(q[0].op));
            check("out_imm", out_imm, q[0].imm);
        end
    endtask

    // One clock: drive at negedge, compare, advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        logic can_take;
        logic has_out;
        exp_t e;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        compare_outputs();
        can_take = (q.size() < 2);
        has_out  = (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (has_out && ordy) void'(q.pop_front());
            if (v && can_take) begin
                e.inst = inst;
                e.pc   = pc;
                e.op   = ref_op(inst);
                e.imm  = ref_imm(inst);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] inst,
                              input imm_op_enum op, input logic [63:0] imm);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_inst"}, 64'(out_inst), 64'(inst));
        check({name, "_op"}, 64'(out_imm_op), 64'(op));
        check({name, "_imm"}, out_imm, imm);
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset(input string name);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1 rst = 1'b1;
        #1;
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        check({name, "_inst"}, 64'(out_inst), 64'd0);
        check({name, "_pc"}, out_pc, 64'd0);
        check({name, "_imm"}, out_imm, 64'd0);
        check({name, "_op"}, 64'(out_imm_op), 64'(IMM0));
        q.delete();
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  tab [10];
        logic [31:0] r;
        int unsigned idx;
        logic [6:0]  opc;
        tab = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        r   = $urandom();
        idx = $urandom_range(0, 10);
        opc = (idx == 10) ? r[6:0] : tab[idx];
        return {r[31:7], opc};
    endfunction

    initial begin
        logic [31:0] i1, i2, i3;
        logic [31:0] r0, r1;

        // Reset held from time zero.
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_inst", 64'(out_inst), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_imm", out_imm, 64'd0);
        check("rst_op", 64'(out_imm_op), 64'(IMM0));
        rst = 1'b0;
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // addi x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
        expect_out("addi", 32'hFFF00093, I_IMM, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_pc", out_pc, 64'h1000);

        // Back-to-back stream with downstream always ready.
        cycle(1'b1, 32'h00112623, 64'h1004, 1'b1, 1'b0);
        expect_out("sw", 32'h00112623, S_IMM, 64'hC);
        cycle(1'b1, 32'hFE000EE3, 64'h1008, 1'b1, 1'b0);
        expect_out("beq", 32'hFE000EE3, B_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 32'h123450B7, 64'h100C, 1'b1, 1'b0);
        expect_out("lui", 32'h123450B7, U_IMM, 64'h1234_5000);
        cycle(1'b1, 32'h0080006F, 64'h1010, 1'b1, 1'b0);
        expect_out("jal", 32'h0080006F, UJ_IMM, 64'h8);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: third instruction must wait upstream.
        i1 = 32'h00A00093;
        i2 = 32'h00112623;
        i3 = 32'h0080006F;
        cycle(1'b1, i1, 64'h2000, 1'b0, 1'b0);
        check("bp_ready1", 64'(in_ready), 64'd1);
        cycle(1'b1, i2, 64'h2004, 1'b0, 1'b0);
        check("bp_ready2", 64'(in_ready), 64'd0);
        cycle(1'b1, i3, 64'h2008, 1'b0, 1'b0);
        check("bp_hold", 64'(out_inst), 64'(i1));
        cycle(1'b1, i3, 64'h2008, 1'b1, 1'b0);
        check("bp_second", 64'(out_inst), 64'(i2));
        cycle(1'b1, i3, 64'h2008, 1'b1, 1'b0);
        check("bp_third", 64'(out_inst), 64'(i3));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush from FULL with a concurrent valid input.
        cycle(1'b1, 32'h00000013, 64'h3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00100013, 64'h3004, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200013, 64'h3008, 1'b0, 1'b1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset while HALF, then an R-type instruction.
        cycle(1'b1, 32'h00500093, 64'h4000, 1'b0, 1'b0);
        async_reset("arst");
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h00000033, 64'h5000, 1'b1, 1'b0);
        expect_out("rtype", 32'h00000033, IMM0, 64'd0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            r0 = $urandom();
            r1 = $urandom();
            cycle($urandom_range(0, 3) != 0, rand_inst(), {r0, r1},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            if (n % 700 == 699) async_reset("rand_arst");
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
